// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 32-entry register file with per-register pending-write scoreboard
// Issue stalls on RAW hazards or a saturated pending counter; write-back bypasses into reads and stall logic.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rs,
  input  logic [4:0]        iss_rt,
  input  logic              iss_wr,
  input  logic [4:0]        iss_dst,
  output logic              iss_stall,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              sb_err
);

  localparam logic [CNT_W-1:0] MAX_PEND = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] regs [32];
  logic [CNT_W-1:0]  cnt  [32];

  logic              wb_live;
  logic              hit_rs, hit_rt, hit_dst;
  logic [CNT_W-1:0]  cnt_rs, cnt_rt, cnt_dst;
  logic              busy_rs, busy_rt, full_dst;
  logic              iss_fire;
  logic [31:0]       inc_vec, dec_vec;

  // Register 0 is never a write-back target, so every hit below is implicitly nonzero.
  assign wb_live = wb_valid & (wb_addr != 5'd0);
  assign hit_rs  = wb_live & (wb_addr == iss_rs);
  assign hit_rt  = wb_live & (wb_addr == iss_rt);
  assign hit_dst = wb_live & (wb_addr == iss_dst);

  assign cnt_rs  = cnt[iss_rs];
  assign cnt_rt  = cnt[iss_rt];
  assign cnt_dst = cnt[iss_dst];

  // A source is still busy unless its last outstanding write is completing right now.
  assign busy_rs  = (cnt_rs != '0) & ~((cnt_rs == CNT_ONE) & hit_rs);
  assign busy_rt  = (cnt_rt != '0) & ~((cnt_rt == CNT_ONE) & hit_rt);
  assign full_dst = iss_wr & (iss_dst != 5'd0) & (cnt_dst == MAX_PEND) & ~hit_dst;

  assign iss_stall = iss_valid & (busy_rs | busy_rt | full_dst);
  assign iss_fire  = iss_valid & ~iss_stall;

  assign rd_data1 = (iss_rs == 5'd0) ? '0 : (hit_rs ? wb_data : regs[iss_rs]);
  assign rd_data2 = (iss_rt == 5'd0) ? '0 : (hit_rt ? wb_data : regs[iss_rt]);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (iss_fire & iss_wr & (iss_dst != 5'd0)) begin
      inc_vec[iss_dst] = 1'b1;
    end
    if (wb_live & (cnt[wb_addr] != '0)) begin
      dec_vec[wb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_live) begin
        regs[wb_addr] <= wb_data;
      end
      // Simultaneous issue and retire on one register cancel out.
      for (int i = 0; i < 32; i++) begin
        if (inc_vec[i] & ~dec_vec[i]) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end else if (dec_vec[i] & ~inc_vec[i]) begin
          cnt[i] <= cnt[i] - CNT_ONE;
        end
      end
      if (wb_live & (cnt[wb_addr] == '0)) begin
        sb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and model-checked bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs, iss_rt, iss_dst;
  logic        iss_wr;
  logic        iss_stall;
  logic [31:0] rd_data1, rd_data2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sb_err;

  int vecs = 0;
  int errs = 0;

  regfile_scoreboard #(.DATA_W(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_wr(iss_wr), .iss_dst(iss_dst), .iss_stall(iss_stall),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_wr = 0; iss_dst = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic wr, input logic [4:0] dst);
    iss_valid = 1; iss_rs = rs; iss_rt = rt; iss_wr = wr; iss_dst = dst;
  endtask

  task automatic test_reset();
    clr(); rst = 1; tick(); tick(); rst = 0;
    issue(5, 31, 1, 5); #1;
    vecs++; if (iss_stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", iss_stall); errs++; end
    vecs++; if (rd_data1 !== 32'h0) begin $display("FAIL reset_rd1: got %h want 0", rd_data1); errs++; end
    vecs++; if (rd_data2 !== 32'h0) begin $display("FAIL reset_rd2: got %h want 0", rd_data2); errs++; end
    vecs++; if (sb_err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", sb_err); errs++; end
    clr();
  endtask

  task automatic test_raw_bypass();
    issue(0, 0, 1, 5); #1;
    vecs++; if (iss_stall !== 1'b0) begin $display("FAIL raw_first_issue: got %b want 0", iss_stall); errs++; end
    tick(); clr();
    issue(5, 0, 0, 0); #1;
    vecs++; if (iss_stall !== 1'b1) begin $display("FAIL raw_stall: got %b want 1", iss_stall); errs++; end
    wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; #1;
    vecs++; if (iss_stall !== 1'b0) begin $display("FAIL raw_wb_release: got %b want 0", iss_stall); errs++; end
    vecs++; if (rd_data1 !== 32'hDEADBEEF) begin $display("FAIL raw_bypass: got %h want deadbeef", rd_data1); errs++; end
    tick(); clr();
    issue(5, 5, 0, 0); #1;
    vecs++; if (iss_stall !== 1'b0) begin $display("FAIL raw_after_wb_stall: got %b want 0", iss_stall); errs++; end
    vecs++; if (rd_data2 !== 32'hDEADBEEF) begin $display("FAIL raw_stored: got %h want deadbeef", rd_data2); errs++; end
    vecs++; if (sb_err !== 1'b0) begin $display("FAIL raw_err: got %b want 0", sb_err); errs++; end
    clr();
  endtask

  task automatic test_max_pend();
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, 1, 7); #1;
      vecs++; if (iss_stall !== 1'b0) begin $display("FAIL pend_fill_%0d: got %b want 0", i, iss_stall); errs++; end
      tick();
    end
    issue(0, 0, 1, 7); #1;
    vecs++; if (iss_stall !== 1'b1) begin $display("FAIL pend_full_stall: got %b want 1", iss_stall); errs++; end
    wb_valid = 1; wb_addr = 7; wb_data = 32'h70; #1;
    vecs++; if (iss_stall !== 1'b0) begin $display("FAIL pend_full_wb: got %b want 0", iss_stall); errs++; end
    tick(); clr();
    issue(0, 0, 1, 7); #1;
    vecs++; if (iss_stall !== 1'b1) begin $display("FAIL pend_still_full: got %b want 1", iss_stall); errs++; end
    clr();
    // Drain the three outstanding writes one per cycle.
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1; wb_addr = 7; wb_data = 32'h71 + i; tick(); clr();
      issue(7, 0, 0, 0); #1;
      vecs++; if (iss_stall !== (i < 2)) begin $display("FAIL pend_drain_%0d: got %b want %b", i, iss_stall, (i < 2)); errs++; end
      clr();
    end
    issue(7, 0, 0, 0); #1;
    vecs++; if (rd_data1 !== 32'h73) begin $display("FAIL pend_last_data: got %h want 73", rd_data1); errs++; end
    vecs++; if (sb_err !== 1'b0) begin $display("FAIL pend_err: got %b want 0", sb_err); errs++; end
    clr();
  endtask

  task automatic test_zero_reg();
    wb_valid = 1; wb_addr = 0; wb_data = 32'h1234; issue(0, 0, 0, 0); #1;
    vecs++; if (rd_data1 !== 32'h0) begin $display("FAIL zero_bypass: got %h want 0", rd_data1); errs++; end
    tick(); clr();
    issue(0, 0, 1, 0); #1;
    vecs++; if (rd_data1 !== 32'h0) begin $display("FAIL zero_read: got %h want 0", rd_data1); errs++; end
    vecs++; if (sb_err !== 1'b0) begin $display("FAIL zero_err: got %b want 0", sb_err); errs++; end
    tick(); clr();
    issue(0, 0, 0, 0); #1;
    vecs++; if (iss_stall !== 1'b0) begin $display("FAIL zero_no_stall: got %b want 0", iss_stall); errs++; end
    clr();
  endtask

  task automatic test_sb_err();
    wb_valid = 1; wb_addr = 9; wb_data = 32'hCAFE0009; #1;
    vecs++; if (sb_err !== 1'b0) begin $display("FAIL err_before: got %b want 0", sb_err); errs++; end
    tick(); clr();
    issue(9, 0, 0, 0); #1;
    vecs++; if (sb_err !== 1'b1) begin $display("FAIL err_set: got %b want 1", sb_err); errs++; end
    vecs++; if (rd_data1 !== 32'hCAFE0009) begin $display("FAIL err_data: got %h want cafe0009", rd_data1); errs++; end
    clr(); tick(); tick(); #1;
    vecs++; if (sb_err !== 1'b1) begin $display("FAIL err_sticky: got %b want 1", sb_err); errs++; end
  endtask

  task automatic test_reset_mid();
    issue(0, 0, 1, 3); tick(); clr();
    issue(3, 0, 0, 0); #1;
    vecs++; if (iss_stall !== 1'b1) begin $display("FAIL mid_pending: got %b want 1", iss_stall); errs++; end
    // Inputs active during reset must be ignored.
    rst = 1; issue(0, 0, 1, 3); wb_valid = 1; wb_addr = 9; wb_data = 32'h99; tick();
    rst = 0; clr();
    issue(3, 9, 0, 0); #1;
    vecs++; if (iss_stall !== 1'b0) begin $display("FAIL mid_stall: got %b want 0", iss_stall); errs++; end
    vecs++; if (rd_data1 !== 32'h0) begin $display("FAIL mid_rd3: got %h want 0", rd_data1); errs++; end
    vecs++; if (rd_data2 !== 32'h0) begin $display("FAIL mid_rd9: got %h want 0", rd_data2); errs++; end
    vecs++; if (sb_err !== 1'b0) begin $display("FAIL mid_err_clr: got %b want 0", sb_err); errs++; end
    clr();
    wb_valid = 1; wb_addr = 3; wb_data = 32'h33; tick(); clr(); #1;
    vecs++; if (sb_err !== 1'b1) begin $display("FAIL mid_stale_wb: got %b want 1", sb_err); errs++; end
  endtask

  task automatic test_random();
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_err;
    logic        e_stall;
    logic [31:0] e_rd1, e_rd2;
    int          p;
    clr(); rst = 1; tick(); rst = 0;
    for (int r = 0; r < 32; r++) begin m_reg[r] = 0; m_cnt[r] = 0; end
    m_err = 0;
    for (int c = 0; c < 400; c++) begin
      iss_valid = ($urandom_range(0, 3) != 0);
      iss_rs = 5'($urandom_range(0, 7)); iss_rt = 5'($urandom_range(0, 7));
      iss_wr = ($urandom_range(0, 2) != 0); iss_dst = 5'($urandom_range(0, 7));
      wb_valid = $urandom_range(0, 1); wb_data = $urandom;
      wb_addr = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 15) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_cnt[(wb_addr + k) % 8] > 0) begin wb_addr = 5'((wb_addr + k) % 8); break; end
        end
      end
      e_stall = 0;
      if (iss_valid) begin
        p = m_cnt[iss_rs]; if (wb_valid && wb_addr == iss_rs && iss_rs != 0 && p > 0) p--;
        if (p != 0) e_stall = 1;
        p = m_cnt[iss_rt]; if (wb_valid && wb_addr == iss_rt && iss_rt != 0 && p > 0) p--;
        if (p != 0) e_stall = 1;
        if (iss_wr && iss_dst != 0 && m_cnt[iss_dst] == 3 && !(wb_valid && wb_addr == iss_dst)) e_stall = 1;
      end
      e_rd1 = (iss_rs == 0) ? 0 : (wb_valid && wb_addr == iss_rs) ? wb_data : m_reg[iss_rs];
      e_rd2 = (iss_rt == 0) ? 0 : (wb_valid && wb_addr == iss_rt) ? wb_data : m_reg[iss_rt];
      #1;
      vecs++; if (iss_stall !== e_stall) begin $display("FAIL rnd_stall c=%0d: got %b want %b", c, iss_stall, e_stall); errs++; end
      vecs++; if (rd_data1 !== e_rd1) begin $display("FAIL rnd_rd1 c=%0d: got %h want %h", c, rd_data1, e_rd1); errs++; end
      vecs++; if (rd_data2 !== e_rd2) begin $display("FAIL rnd_rd2 c=%0d: got %h want %h", c, rd_data2, e_rd2); errs++; end
      vecs++; if (sb_err !== m_err) begin $display("FAIL rnd_err c=%0d: got %b want %b", c, sb_err, m_err); errs++; end
      if (wb_valid && wb_addr != 0) begin
        m_reg[wb_addr] = wb_data;
        if (m_cnt[wb_addr] == 0) m_err = 1; else m_cnt[wb_addr]--;
      end
      if (iss_valid && !e_stall && iss_wr && iss_dst != 0) m_cnt[iss_dst]++;
      tick();
    end
    clr();
  endtask

  initial begin
    clr(); rst = 1;
    @(negedge clk);
    test_reset();
    test_raw_bypass();
    test_max_pend();
    test_zero_reg();
    test_sb_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter CNT_W, default 2, width of the per-register pending counter; MAX_PEND = 2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 iss_valid  input  1  decode stage presents an instruction.
REQ-006 iss_rs  input  5  first source register number.
REQ-007 iss_rt  input  5  second source register number.
REQ-008 iss_wr  input  1  instruction writes a destination register.
REQ-009 iss_dst  input  5  destination register number, from the rt/rd select.
REQ-010 iss_stall  output  1  issue blocked this cycle.
REQ-011 rd_data1  output  DATA_W  value of iss_rs, combinational.
REQ-012 rd_data2  output  DATA_W  value of iss_rt, combinational.
REQ-013 wb_valid  input  1  write-back strobe.
REQ-014 wb_addr  input  5  write-back register number.
REQ-015 wb_data  input  DATA_W  write-back value.
REQ-016 sb_err  output  1  sticky: write-back to register with zero pending count.

Function
REQ-017 Storage: 32 x DATA_W registers plus 32 CNT_W-bit pending counters; register 0 reads 0, never written, counter permanently 0.
REQ-018 iss_fire = iss_valid & ~iss_stall; an issue is accepted only on iss_fire.
REQ-019 wb_hit(r) = wb_valid & (wb_addr == r) & (r != 0).
REQ-020 pend_eff(r) = cnt[r] - (wb_hit(r) ? 1 : 0), evaluated combinationally (0 when cnt[r] = 0).
REQ-021 iss_stall = iss_valid & ( pend_eff(iss_rs)!=0 | pend_eff(iss_rt)!=0 | (iss_wr & iss_dst!=0 & cnt[iss_dst]==MAX_PEND & ~wb_hit(iss_dst)) ); iss_stall = 0 when iss_valid = 0.
REQ-022 rd_data1/2: 0 if address 0; else wb_data if wb_hit(address) (write-first bypass); else stored value.
REQ-023 On wb_hit(r): reg[r] <= wb_data next edge; cnt[r] decrements if nonzero.
REQ-024 On iss_fire & iss_wr & iss_dst != 0: cnt[iss_dst] increments.
REQ-025 Same-cycle issue and write-back to same register: counter net unchanged; data still written.
REQ-026 Counter never wraps: increment at MAX_PEND is impossible by REQ-021; decrement at 0 does not occur.
REQ-027 wb_valid with wb_addr != 0 and cnt[wb_addr] == 0: data written, counter stays 0, sb_err set to 1 and held until reset.
REQ-028 wb_valid with wb_addr == 0: no state change, no error.
REQ-029 No internal latency beyond one edge: counter/data updates visible to stall and read logic in the cycle after the edge.

Reset
REQ-030 While rst = 1 at an edge: all 32 registers <= 0, all counters <= 0, sb_err <= 0; issue and write-back inputs ignored that cycle.
REQ-031 After reset: iss_stall = 0 for any issue, rd_data1 = rd_data2 = 0 until first write-back.
REQ-032 Reset asserted mid-operation discards all pending counts; subsequent write-backs of pre-reset instructions set sb_err.

Verification
REQ-033 Issue wr dst=5; next cycle issue rs=5 -> iss_stall=1; wb 5 data 0xDEADBEEF same cycle -> iss_stall=0, rd_data1=0xDEADBEEF.
REQ-034 Issue dst=7 three times (CNT_W=2) -> fourth issue dst=7 stalls; same cycle wb_addr=7 -> fourth accepted, cnt[7] stays 3.
REQ-035 wb_addr=0 data 0x1234, then read rs=0 -> rd_data1=0, sb_err=0, no stall.
REQ-036 wb_addr=9 with cnt[9]=0 -> reg[9] updated, sb_err=1 and stays 1 until rst.
REQ-037 Issue dst=3, assert rst one cycle -> cnt[3]=0, reg[3]=0; issue rs=3 -> iss_stall=0, rd_data1=0.
REQ-038 Random issue/write-back stream vs. reference model: stall, read data, sb_err match every cycle.
